// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational product.
module mdu_iter #(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             a_neg_q, a_neg_d;

   logic             accept, is_div, signed_a, signed_b, a_neg, b_neg;
   logic             div_zero, div_ovf, bypass, mul_fast;
   logic [WIDTH-1:0] a_mag, b_mag, byp_val;
`ifdef MDU_FAST_MUL_EN
   logic [WIDTH:0]     fa_ext, fb_ext;
   logic [2*WIDTH-1:0] fprod;
`endif

   // Request decode: operand magnitudes, result signs and the bypass cases.
   always_comb begin
      accept   = in_valid && !flush && (state_q == S_IDLE);
      is_div   = op[2];
      signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_neg    = signed_a & a[WIDTH-1];
      b_neg    = signed_b & b[WIDTH-1];
      a_mag    = a_neg ? -a : a;
      b_mag    = b_neg ? -b : b;
      div_zero = is_div && (b == '0);
      div_ovf  = is_div && !op[0] && (a == MIN_NEG) && (b == '1);
      bypass   = div_zero || div_ovf;
      if (div_zero) byp_val = op[1] ? a : '1;
      else          byp_val = op[1] ? '0 : a;
`ifdef MDU_FAST_MUL_EN
      mul_fast = !is_div;
      fa_ext   = {signed_a & a[WIDTH-1], a};
      fb_ext   = {signed_b & b[WIDTH-1], b};
      fprod    = {{(WIDTH-1){fa_ext[WIDTH]}}, fa_ext} * {{(WIDTH-1){fb_ext[WIDTH]}}, fb_ext};
`else
      mul_fast = 1'b0;
`endif
   end

   logic [WIDTH:0]     mul_sum, rem_sh;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;

   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
      rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge   = rem_sh >= {1'b0, opb_q};
      prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
      quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
      rem_fix  = a_neg_q ? -acc_hi_q : acc_hi_q;
      case (op_q)
         3'b000:                 fix_val = prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fix_val = quo_fix;
         default:                fix_val = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = (bypass || mul_fast) ? S_DONE : S_CALC;
         S_CALC:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // A flushed DONE never exposes pend_q, so the visible result keeps its old value.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      busy      = (state_q == S_CALC) || (state_q == S_FIX);
      out_valid = (state_q == S_DONE) && !flush;
      result    = out_valid ? pend_q : res_q;
   end

   always_comb begin
      op_d     = op_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      pend_d   = pend_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      a_neg_d  = a_neg_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d     = op;
               cnt_d    = '0;
               neg_d    = a_neg ^ b_neg;
               a_neg_d  = a_neg;
               acc_hi_d = '0;
               acc_lo_d = is_div ? a_mag : b_mag;
               opb_d    = is_div ? b_mag : a_mag;
               if (bypass) pend_d = byp_val;
`ifdef MDU_FAST_MUL_EN
               else if (mul_fast) pend_d = (op == 3'b000) ? fprod[WIDTH-1:0] : fprod[2*WIDTH-1:WIDTH];
`endif
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_q[2]) begin
               acc_hi_d = div_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            end else begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
         end
         S_FIX:   pend_d = fix_val;
         S_DONE:  if (!flush) res_d = pend_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
         pend_q   <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
      end else begin
         op_q     <= op_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         pend_q   <= pend_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         a_neg_q  <= a_neg_d;
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, flush/reset corner sequences and random ops
// checked against an arithmetic reference model. Latency is the count of negedge samples after the capture edge.
module tb_mdu_iter;

   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = W + 2;
`endif
   localparam int DL = W + 2;

   logic         clk, rst_n, in_valid, in_ready, flush, out_valid, busy;
   logic [2:0]   op;
   logic [W-1:0] a, b, result;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_res;
   int           checks, errors;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t vecs[18];

   mdu_iter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .flush(flush),
      .out_valid(out_valid), .result(result), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model straight from the RV32M definitions using 64-bit arithmetic.
   function automatic logic [W-1:0] ref_mdu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint      sx, sy, ux, uy;
      logic [63:0] p;
      sx = $signed(x);
      sy = $signed(y);
      ux = {32'd0, x};
      uy = {32'd0, y};
      p  = '0;
      case (o)
         3'd0: begin p = sx * sy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * uy; return p[63:32]; end
         3'd3: begin p = ux * uy; return p[63:32]; end
         3'd4: begin
            if (y == 0) return '1;
            if (x == 32'h8000_0000 && y == '1) return x;
            return 32'(sx / sy);
         end
         3'd5: return (y == 0) ? '1 : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == '1) return '0;
            return 32'(sx % sy);
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == '1))) return 1;
      if (!o[2]) return ML;
      return DL;
   endfunction

   function automatic logic [W-1:0] pick();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(input string name, input int exp_lat);
      logic [W-1:0] exp_res;
      int           n;
      bit           seen, rdy_bad;
      exp_res = exp_q.pop_front();
      n = 0; seen = 1'b0; rdy_bad = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 1 && exp_lat > 1) chk({name, "_busy"}, W'(busy), 1);
         if (out_valid) seen = 1'b1;
         else if (in_ready) rdy_bad = 1'b1;
      end
      chk({name, "_out_valid_seen"}, W'(seen), 1);
      if (seen) begin
         chk({name, "_result"}, result, exp_res);
         chk({name, "_latency"}, W'(n), W'(exp_lat));
         chk({name, "_in_ready_low"}, W'(rdy_bad | in_ready), 0);
         chk({name, "_busy_done"}, W'(busy), 0);
         @(negedge clk);
         chk({name, "_one_cycle"}, W'(out_valid), 0);
         chk({name, "_in_ready_back"}, W'(in_ready), 1);
         chk({name, "_result_held"}, result, exp_res);
         last_res = exp_res;
      end
   endtask

   task automatic quiet_window(input string name, input int cycles);
      bit any;
      any = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid) any = 1'b1;
      end
      chk(name, W'(any), 0);
   endtask

   initial begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;

      checks = 0; errors = 0; last_res = '0;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;

      vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, ML};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DL};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DL};
      vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'h0000_000E, DL};
      vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'h0000_0002, DL};
      vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'h0000_0005, 1};
      vecs[10] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[11] = '{3'd6, 32'd5,         32'd0,         32'h0000_0005, 1};
      vecs[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[14] = '{3'd4, 32'h8000_0000, 32'd1,         32'h8000_0000, DL};
      vecs[15] = '{3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780, ML};
      vecs[16] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DL};
      vecs[17] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, DL};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", W'(in_ready), 1);
      chk("reset_out_valid", W'(out_valid), 0);
      chk("reset_busy", W'(busy), 0);
      chk("reset_result", result, '0);

      for (int i = 0; i < 18; i++) begin
         exp_q.push_back(vecs[i].exp);
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_result($sformatf("vec%0d", i), vecs[i].lat);
      end

      // Flush on the tenth CALC cycle: nothing comes out and result is untouched.
      issue(3'd5, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_calc_in_ready", W'(in_ready), 1);
      chk("flush_calc_result", result, last_res);
      quiet_window("flush_calc_no_valid", 40);
      exp_q.push_back(32'd3);
      issue(3'd5, 32'd9, 32'd3);
      wait_result("after_flush_divu", DL);

      // Flush while DONE: the strobe is suppressed in that same cycle.
      issue(3'd4, 32'd5, 32'd0);
      flush = 1'b1;
      #1;
      chk("flush_done_out_valid", W'(out_valid), 0);
      chk("flush_done_result", result, last_res);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_done_in_ready", W'(in_ready), 1);
      quiet_window("flush_done_no_valid", 5);

      // Flush in IDLE blocks the request.
      @(negedge clk);
      op = 3'd5; a = 32'd9; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 begin in_valid = 1'b0; flush = 1'b0; end
      @(negedge clk);
      chk("flush_idle_in_ready", W'(in_ready), 1);
      chk("flush_idle_busy", W'(busy), 0);
      quiet_window("flush_idle_no_valid", 40);

      // Asynchronous reset in the middle of CALC.
      issue(3'd4, 32'd1000, 32'd7);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", W'(in_ready), 1);
      chk("arst_busy", W'(busy), 0);
      chk("arst_out_valid", W'(out_valid), 0);
      chk("arst_result", result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      last_res = '0;
      quiet_window("arst_no_valid", 40);
      exp_q.push_back(32'd2);
      issue(3'd7, 32'd100, 32'd7);
      wait_result("after_arst_remu", DL);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         exp_q.push_back(ref_mdu(ro, ra, rb));
         issue(ro, ra, rb);
         wait_result($sformatf("rand%0d_op%0d_a%08h_b%08h", i, ro, ra, rb), ref_lat(ro, ra, rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
